// File: rtl/cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_ctrl
// Purpose  : Single-outstanding CPU-to-slave bus controller. Decodes a
//            3-bit channel index from the request address, selects one of
//            NCH slaves, waits for that slave's ack and returns a one-cycle
//            completion pulse with read data and an error flag to the CPU.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            cpu_bc_req/rw/addr/data      - CPU request side
//            bc_cpu_data/ack/err/stall    - CPU response side
//            sl_sel/addr/wdata/rw         - slave request side (registered)
//            sl_rdata/sl_ack              - slave response side (packed per channel)
// Options  : CPU_BUS_TIMEOUT_EN - when defined, an ACCESS that sees no slave
//            ack for TIMEOUT cycles completes with err=1 and all-ones data.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_ctrl #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int NCH     = 4,
   parameter int SEL_LO  = 12,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_bc_req,
   input  logic              cpu_bc_rw,
   input  logic [AW-1:0]     cpu_bc_addr,
   input  logic [DW-1:0]     cpu_bc_data,
   output logic [DW-1:0]     bc_cpu_data,
   output logic              bc_cpu_ack,
   output logic              bc_cpu_err,
   output logic              bc_cpu_stall,
   output logic [NCH-1:0]    sl_sel,
   output logic [AW-1:0]     sl_addr,
   output logic [DW-1:0]     sl_wdata,
   output logic              sl_rw,
   input  logic [NCH*DW-1:0] sl_rdata,
   input  logic [NCH-1:0]    sl_ack
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Channel count in the same width as a zero-extended 3-bit index.
   localparam logic [3:0] NCH_L = 4'(NCH);

   // Out-of-range configurations elaborate this empty marker block so they
   // are easy to spot in elaboration reports; no hardware is produced.
   if (NCH < 1 || NCH > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_out_of_range
   end

   state_t            state_q, state_d;
   logic [2:0]        ch_q, ch_d;
   logic [DW-1:0]     data_q, data_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [NCH-1:0]    sel_q, sel_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              rw_q, rw_d;

   logic [2:0]        req_ch;
   logic              slv_ack;
   logic [DW-1:0]     slv_rdata;
   logic              tmo;

   assign req_ch = cpu_bc_addr[SEL_LO+2:SEL_LO];

   // Only the latched channel's ack and read slice are ever looked at.
   always_comb begin
      slv_ack   = 1'b0;
      slv_rdata = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_q == 3'(k)) begin
            slv_ack   = sl_ack[k];
            slv_rdata = sl_rdata[k*DW +: DW];
         end
      end
   end

`ifdef CPU_BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   logic [7:0] tcnt_q, tcnt_d;

   // Held at zero while idle so it is already clear on ACCESS entry;
   // saturates instead of wrapping.
   always_comb begin
      tcnt_d = tcnt_q;
      tmo    = 1'b0;
      if (state_q == ST_IDLE) begin
         tcnt_d = '0;
      end else if (state_q == ST_ACCESS && !slv_ack) begin
         if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
         end
         tmo = (tcnt_d >= TO_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   // Next-state and registered-output logic. Response outputs default to
   // zero so ack/err/data are only non-zero for the single RESP cycle.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      sel_d   = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_bc_req) begin
               ch_d    = req_ch;
               addr_d  = cpu_bc_addr;
               wdata_d = cpu_bc_data;
               rw_d    = cpu_bc_rw;
               if ({1'b0, req_ch} < NCH_L) begin
                  state_d = ST_ACCESS;
                  for (int k = 0; k < NCH; k++) begin
                     sel_d[k] = (req_ch == 3'(k));
                  end
               end else begin
                  // No such channel: answer straight away with an error.
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end

         ST_ACCESS: begin
            sel_d = sel_q;
            if (slv_ack) begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               data_d  = rw_q ? '0 : slv_rdata;
               sel_d   = '0;
            end else if (tmo) begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               data_d  = '1;
               sel_d   = '0;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
      end
   end

   assign bc_cpu_data  = data_q;
   assign bc_cpu_ack   = ack_q;
   assign bc_cpu_err   = err_q;
   assign sl_sel       = sel_q;
   assign sl_addr      = addr_q;
   assign sl_wdata     = wdata_q;
   assign sl_rw        = rw_q;

   // Stall is combinational on the request so the CPU holds in the very
   // cycle its request is accepted.
   assign bc_cpu_stall = (state_q == ST_IDLE && cpu_bc_req) || (state_q == ST_ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_ctrl
// Purpose  : Self-checking bench for cpu_bus_ctrl with default parameters.
//            Each transfer's expected cycle-by-cycle behaviour is derived
//            from its channel, direction and slave delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_ctrl;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int NCH     = 4;
   localparam int SEL_LO  = 12;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_bc_req;
   logic              cpu_bc_rw;
   logic [AW-1:0]     cpu_bc_addr;
   logic [DW-1:0]     cpu_bc_data;
   logic [DW-1:0]     bc_cpu_data;
   logic              bc_cpu_ack;
   logic              bc_cpu_err;
   logic              bc_cpu_stall;
   logic [NCH-1:0]    sl_sel;
   logic [AW-1:0]     sl_addr;
   logic [DW-1:0]     sl_wdata;
   logic              sl_rw;
   logic [NCH*DW-1:0] sl_rdata;
   logic [NCH-1:0]    sl_ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpu_bus_ctrl #(
      .DW(DW), .AW(AW), .NCH(NCH), .SEL_LO(SEL_LO), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_bc_req(cpu_bc_req), .cpu_bc_rw(cpu_bc_rw),
      .cpu_bc_addr(cpu_bc_addr), .cpu_bc_data(cpu_bc_data),
      .bc_cpu_data(bc_cpu_data), .bc_cpu_ack(bc_cpu_ack),
      .bc_cpu_err(bc_cpu_err), .bc_cpu_stall(bc_cpu_stall),
      .sl_sel(sl_sel), .sl_addr(sl_addr), .sl_wdata(sl_wdata), .sl_rw(sl_rw),
      .sl_rdata(sl_rdata), .sl_ack(sl_ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transfer, starting at the falling edge of an IDLE cycle and ending
   // at the falling edge of the IDLE cycle after RESP.
   // dly >= 0 : slave acks in ACCESS cycle number dly (0 = first)
   // dly <  0 : slave never acks (timeout build only)
   task automatic xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input bit hold);
      int         ch;
      bit         dec;
      int         n_acc;
      logic [3:0] exp_sel;
      logic       exp_err;
      logic [31:0] exp_data;

      ch       = int'(addr[SEL_LO +: 3]);
      dec      = (ch >= NCH);
      exp_sel  = dec ? 4'd0 : 4'(1 << ch);
      n_acc    = dec ? 0 : ((dly < 0) ? TIMEOUT : dly + 1);
      exp_err  = dec || (dly < 0);
      exp_data = (dly < 0 && !dec) ? 32'hFFFF_FFFF : ((dec || rw) ? 32'h0 : rd);

      // IDLE: present the request
      cpu_bc_req  = 1'b1;
      cpu_bc_rw   = rw;
      cpu_bc_addr = addr;
      cpu_bc_data = wd;
      sl_ack      = 4'($urandom);
      #1;
      chk("idle_ack", bc_cpu_ack, 1'b0);
      chk("idle_sel", sl_sel, 4'd0);
      chk("idle_stall", bc_cpu_stall, 1'b1);
      @(negedge clk);

      // ACCESS cycles; CPU-side and unselected-slave noise must be ignored
      for (int c = 0; c < n_acc; c++) begin
         cpu_bc_req  = 1'($urandom);
         cpu_bc_rw   = 1'($urandom);
         cpu_bc_addr = $urandom;
         cpu_bc_data = $urandom;
         for (int k = 0; k < NCH; k++) sl_rdata[k*DW +: DW] = $urandom;
         sl_rdata[ch*DW +: DW] = rd;
         sl_ack = 4'($urandom) & ~exp_sel;
         if (dly >= 0 && c == dly) sl_ack = sl_ack | exp_sel;
         #1;
         chk("acc_sel", sl_sel, exp_sel);
         chk("acc_ack", bc_cpu_ack, 1'b0);
         chk("acc_stall", bc_cpu_stall, 1'b1);
         chk("acc_addr", sl_addr, addr);
         chk("acc_wdata", sl_wdata, wd);
         chk("acc_rw", sl_rw, rw);
         @(negedge clk);
      end

      // RESP
      cpu_bc_req  = hold;
      cpu_bc_addr = $urandom;
      cpu_bc_data = $urandom;
      sl_ack      = 4'($urandom);
      #1;
      chk("resp_ack", bc_cpu_ack, 1'b1);
      chk("resp_err", bc_cpu_err, exp_err);
      chk("resp_data", bc_cpu_data, exp_data);
      chk("resp_sel", sl_sel, 4'd0);
      chk("resp_stall", bc_cpu_stall, 1'b0);
      chk("resp_addr", sl_addr, addr);
      chk("resp_wdata", sl_wdata, wd);
      chk("resp_rw", sl_rw, rw);
      @(negedge clk);
      if (!hold) cpu_bc_req = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, bc_cpu_data, 32'h0);
      chk({tag, "_ack"}, bc_cpu_ack, 1'b0);
      chk({tag, "_err"}, bc_cpu_err, 1'b0);
      chk({tag, "_sel"}, sl_sel, 4'd0);
      chk({tag, "_addr"}, sl_addr, 32'h0);
      chk({tag, "_wdata"}, sl_wdata, 32'h0);
      chk({tag, "_rw"}, sl_rw, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;

      rst = 1'b1;
      cpu_bc_req = 1'b0; cpu_bc_rw = 1'b0; cpu_bc_addr = '0; cpu_bc_data = '0;
      sl_rdata = '0; sl_ack = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_stall", bc_cpu_stall, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Read from slave 1, ack in first ACCESS cycle
      xfer(1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678, 0, 1'b0);
      // Write to slave 3, ack after 4 wait cycles
      xfer(1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 4, 1'b0);
      // Decode error (channel 5 with 4 channels)
      xfer(1'b0, 32'h0000_5000, 32'h0, 32'h0, 0, 1'b0);
      // Back-to-back reads with request held through RESP
      xfer(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 0, 1'b1);
      xfer(1'b0, 32'h0000_2020, 32'h0, 32'hCAFE_0002, 1, 1'b0);

      // Reset in the middle of an ACCESS
      cpu_bc_req = 1'b1; cpu_bc_rw = 1'b0; cpu_bc_addr = 32'h0000_2000; cpu_bc_data = 32'h55;
      sl_ack = '0;
      @(negedge clk);
      cpu_bc_req = 1'b0;
      #1;
      chk("rstacc_sel", sl_sel, 4'b0100);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("rstacc");
      chk("rstacc_stall", bc_cpu_stall, 1'b0);
      @(negedge clk);
      #1;
      chk("rstacc_noack", bc_cpu_ack, 1'b0);
      @(negedge clk);
      xfer(1'b0, 32'h0000_2008, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

`ifdef CPU_BUS_TIMEOUT_EN
      xfer(1'b0, 32'h0000_2000, 32'h0, 32'h0, -1, 1'b0);
`endif

      // Randomised transfers over all 8 channel indices
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         xfer(1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 4)),
              1'($urandom));
      end
      cpu_bc_req = 1'b0;
      @(negedge clk);
      #1;
      chk("final_idle_ack", bc_cpu_ack, 1'b0);
      chk("final_idle_sel", sl_sel, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
